// File: rtl/anim_sprite_renderer.sv
// Animated, power-of-two scaled, palette-indexed sprite layer for the pixel pipeline.
// Latency: pixel/opaque lag hcount/vcount by exactly 4 pixel_clk edges.
// Backpressure: none; streams one pixel per clock in lock-step with the raster.
module anim_sprite_renderer #(
    parameter int         WIDTH           = 180,
    parameter int         HEIGHT          = 180,
    parameter int         FRAMES          = 4,
    parameter int         SCALE_LOG2      = 0,
    parameter int         FRAME_PERIOD    = 8,
    parameter int         ROM_AW          = 20,
    parameter logic [7:0] TRANSPARENT_IDX = 8'h00
) (
    input  logic              pixel_clk,
    input  logic              reset,
    input  logic [10:0]       x,
    input  logic [9:0]        y,
    input  logic [10:0]       hcount,
    input  logic [9:0]        vcount,
    input  logic              frame_tick,
    input  logic [1:0]        mode,
    input  logic [7:0]        frame_sel,
    input  logic              start,
    output logic [ROM_AW-1:0] rom_addr,
    input  logic [7:0]        rom_data,
    output logic [7:0]        cmap_addr,
    input  logic [23:0]       cmap_data,
    output logic [23:0]       pixel,
    output logic              opaque,
    output logic [7:0]        cur_frame,
    output logic              done
);

    localparam logic [11:0] SPR_W     = 12'(WIDTH << SCALE_LOG2);
    localparam logic [11:0] SPR_H     = 12'(HEIGHT << SCALE_LOG2);
    localparam logic [31:0] W32       = 32'(WIDTH);
    localparam logic [31:0] FRAME_SZ  = 32'(WIDTH * HEIGHT);
    localparam logic [7:0]  LAST      = 8'(FRAMES - 1);
    localparam int          TW        = (FRAME_PERIOD > 1) ? $clog2(FRAME_PERIOD) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(FRAME_PERIOD - 1);

    typedef enum logic {RUN, STOPPED} state_t;

    state_t        state;
    logic [TW-1:0] tick_cnt;
    logic          dir_up;
    logic [11:0]   hc, vc, px, py, rel_x, rel_y;
    logic          in_spr;
    logic [2:0]    ins_d;
    logic [7:0]    idx_d2, idx_d3;
    logic [7:0]    cur_c, sel_c, nxt_up;
    logic          anim_step;

    // 12-bit compares so a sprite hanging off the right/bottom edge clips instead of wrapping
    always_comb begin
        hc       = {1'b0, hcount};
        vc       = {2'b0, vcount};
        px       = {1'b0, x};
        py       = {2'b0, y};
        rel_x    = hc - px;
        rel_y    = vc - py;
        in_spr   = (hc >= px) && (hc < px + SPR_W) && (vc >= py) && (vc < py + SPR_H);
        rom_addr = ROM_AW'(32'(cur_frame) * FRAME_SZ
                         + 32'(rel_y >> SCALE_LOG2) * W32
                         + 32'(rel_x >> SCALE_LOG2));
    end

    // ins_d[2] plus the registered output form the 4-deep inside-flag delay
    always_ff @(posedge pixel_clk) begin
        if (reset) begin
            ins_d     <= '0;
            idx_d2    <= '0;
            idx_d3    <= '0;
            cmap_addr <= '0;
            pixel     <= '0;
            opaque    <= 1'b0;
        end else begin
            ins_d     <= {ins_d[1:0], in_spr};
            cmap_addr <= rom_data;
            idx_d2    <= rom_data;
            idx_d3    <= idx_d2;
            if (ins_d[2] && (idx_d3 != TRANSPARENT_IDX)) begin
                pixel  <= cmap_data;
                opaque <= 1'b1;
            end else begin
                pixel  <= '0;
                opaque <= 1'b0;
            end
        end
    end

    always_comb begin
        cur_c     = (cur_frame > LAST) ? LAST : cur_frame;
        sel_c     = (frame_sel > LAST) ? LAST : frame_sel;
        nxt_up    = (cur_c >= LAST) ? LAST : cur_c + 8'd1;
        anim_step = frame_tick && (tick_cnt == TICK_LAST);
    end

    // cur_frame only moves on frame_tick so a frame is never torn mid-scan
    always_ff @(posedge pixel_clk) begin
        if (reset) begin
            cur_frame <= '0;
            tick_cnt  <= '0;
            dir_up    <= 1'b1;
            state     <= RUN;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                cur_frame <= '0;
                tick_cnt  <= '0;
                dir_up    <= 1'b1;
                state     <= RUN;
            end else if (frame_tick) begin
                tick_cnt  <= anim_step ? '0 : tick_cnt + TW'(1);
                cur_frame <= cur_c;
                case (mode)
                    2'b00: cur_frame <= sel_c;
                    2'b01: if (anim_step) cur_frame <= (cur_c == LAST) ? 8'd0 : cur_c + 8'd1;
                    2'b10: if (anim_step && state == RUN) begin
                        cur_frame <= nxt_up;
                        if (nxt_up == LAST) begin
                            done  <= 1'b1;
                            state <= STOPPED;
                        end
                    end
                    2'b11: if (anim_step) begin
                        if (LAST == 8'd0) begin
                            cur_frame <= 8'd0;
                        end else if (dir_up) begin
                            if (cur_c == LAST) begin
                                dir_up    <= 1'b0;
                                cur_frame <= cur_c - 8'd1;
                            end else begin
                                cur_frame <= cur_c + 8'd1;
                            end
                        end else begin
                            if (cur_c == 8'd0) begin
                                dir_up    <= 1'b1;
                                cur_frame <= 8'd1;
                            end else begin
                                cur_frame <= cur_c - 8'd1;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_anim_sprite_renderer.sv
// Directed bench: four renderer instances with small parameter sets and behavioural ROMs.
module tb_anim_sprite_renderer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset  = 1'b1;
    logic [10:0] hcount = '0;
    logic [9:0]  vcount = '0;
    logic        zero5  = 1'b0;

    logic       tick_a = 1'b0, start_a = 1'b0;
    logic [1:0] mode_a = 2'b00;
    logic [7:0] sel_a  = 8'd0;
    logic       tick_c = 1'b0, start_c = 1'b0;
    logic [1:0] mode_c = 2'b01;
    logic [7:0] sel_c  = 8'd0;
    logic       tick_d = 1'b0, start_d = 1'b0;

    logic [7:0]  rom_addr_a, rom_data_a, cmap_addr_a, cur_a;
    logic [23:0] cmap_data_a, pixel_a;
    logic        opaque_a, done_a;
    logic [7:0]  rom_addr_b, rom_data_b, cmap_addr_b, cur_b;
    logic [23:0] cmap_data_b, pixel_b;
    logic        opaque_b, done_b;
    logic [7:0]  rom_addr_c, rom_data_c, cmap_addr_c, cur_c;
    logic [23:0] cmap_data_c, pixel_c;
    logic        opaque_c, done_c;
    logic [7:0]  rom_addr_d, rom_data_d, cmap_addr_d, cur_d;
    logic [23:0] cmap_data_d, pixel_d;
    logic        opaque_d, done_d;

    // image ROM returns its own address (optionally a hole at 5); palette is grey {i,i,i}
    always @(posedge clk) begin
        rom_data_a  <= (zero5 && rom_addr_a == 8'd5) ? 8'd0 : rom_addr_a;
        cmap_data_a <= {3{cmap_addr_a}};
        rom_data_b  <= rom_addr_b;
        cmap_data_b <= {3{cmap_addr_b}};
        rom_data_c  <= rom_addr_c;
        cmap_data_c <= {3{cmap_addr_c}};
        rom_data_d  <= rom_addr_d;
        cmap_data_d <= {3{cmap_addr_d}};
    end

    anim_sprite_renderer #(.WIDTH(4), .HEIGHT(2), .FRAMES(2), .SCALE_LOG2(0), .FRAME_PERIOD(1), .ROM_AW(8)) u_a (
        .pixel_clk(clk), .reset(reset), .x(11'd10), .y(10'd5), .hcount(hcount), .vcount(vcount),
        .frame_tick(tick_a), .mode(mode_a), .frame_sel(sel_a), .start(start_a),
        .rom_addr(rom_addr_a), .rom_data(rom_data_a), .cmap_addr(cmap_addr_a), .cmap_data(cmap_data_a),
        .pixel(pixel_a), .opaque(opaque_a), .cur_frame(cur_a), .done(done_a));

    anim_sprite_renderer #(.WIDTH(4), .HEIGHT(2), .FRAMES(2), .SCALE_LOG2(1), .FRAME_PERIOD(1), .ROM_AW(8)) u_b (
        .pixel_clk(clk), .reset(reset), .x(11'd0), .y(10'd0), .hcount(hcount), .vcount(vcount),
        .frame_tick(1'b0), .mode(2'b00), .frame_sel(8'd0), .start(1'b0),
        .rom_addr(rom_addr_b), .rom_data(rom_data_b), .cmap_addr(cmap_addr_b), .cmap_data(cmap_data_b),
        .pixel(pixel_b), .opaque(opaque_b), .cur_frame(cur_b), .done(done_b));

    anim_sprite_renderer #(.WIDTH(4), .HEIGHT(2), .FRAMES(3), .SCALE_LOG2(0), .FRAME_PERIOD(2), .ROM_AW(8)) u_c (
        .pixel_clk(clk), .reset(reset), .x(11'd100), .y(10'd100), .hcount(hcount), .vcount(vcount),
        .frame_tick(tick_c), .mode(mode_c), .frame_sel(sel_c), .start(start_c),
        .rom_addr(rom_addr_c), .rom_data(rom_data_c), .cmap_addr(cmap_addr_c), .cmap_data(cmap_data_c),
        .pixel(pixel_c), .opaque(opaque_c), .cur_frame(cur_c), .done(done_c));

    anim_sprite_renderer #(.WIDTH(4), .HEIGHT(2), .FRAMES(3), .SCALE_LOG2(0), .FRAME_PERIOD(1), .ROM_AW(8)) u_d (
        .pixel_clk(clk), .reset(reset), .x(11'd100), .y(10'd100), .hcount(hcount), .vcount(vcount),
        .frame_tick(tick_d), .mode(2'b10), .frame_sel(8'd0), .start(start_d),
        .rom_addr(rom_addr_d), .rom_data(rom_data_d), .cmap_addr(cmap_addr_d), .cmap_data(cmap_data_d),
        .pixel(pixel_d), .opaque(opaque_d), .cur_frame(cur_d), .done(done_d));

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    logic [23:0] exp_a [9]  = '{24'h0, 24'h0, 24'h040404, 24'h050505, 24'h060606, 24'h070707, 24'h0, 24'h0, 24'h0};
    logic [23:0] exp_z [9]  = '{24'h0, 24'h0, 24'h040404, 24'h000000, 24'h060606, 24'h070707, 24'h0, 24'h0, 24'h0};
    logic [23:0] exp_b [10] = '{24'h0, 24'h0, 24'h010101, 24'h010101, 24'h020202, 24'h020202,
                                24'h030303, 24'h030303, 24'h0, 24'h0};
    logic [7:0]  addr_b [8] = '{8'd0, 8'd0, 8'd1, 8'd1, 8'd2, 8'd2, 8'd3, 8'd3};
    logic [7:0]  seq_loop [8]  = '{8'd0, 8'd0, 8'd1, 8'd1, 8'd2, 8'd2, 8'd0, 8'd0};
    logic [7:0]  seq_pp   [12] = '{8'd0, 8'd0, 8'd1, 8'd1, 8'd2, 8'd2, 8'd1, 8'd1, 8'd0, 8'd0, 8'd1, 8'd1};

    initial begin
        logic [23:0] e;

        // reset state
        repeat (3) next_cycle();
        check("rst_pixel_a", pixel_a, 0);
        check("rst_opaque_a", opaque_a, 0);
        check("rst_cur_a", cur_a, 0);
        check("rst_done_a", done_a, 0);
        check("rst_cmap_a", cmap_addr_a, 0);
        check("rst_pixel_b", pixel_b, 0);
        check("rst_cur_c", cur_c, 0);
        check("rst_done_d", done_d, 0);
        reset = 1'b0;
        next_cycle();

        // unscaled sweep across row 1 of the sprite, then with a transparent hole at texel 5
        vcount = 10'd6;
        for (int p = 0; p < 2; p++) begin
            zero5 = (p == 1);
            for (int i = 0; i < 13; i++) begin
                if (i >= 4) begin
                    e = (p == 0) ? exp_a[i-4] : exp_z[i-4];
                    check(p == 0 ? "a_pixel" : "a_key_pixel", pixel_a, e);
                    check(p == 0 ? "a_opaque" : "a_key_opaque", opaque_a, e != 24'h0);
                end
                if (i < 9) hcount = 11'(8 + i);
                next_cycle();
            end
        end
        zero5 = 1'b0;

        // 2x scaling: each texel spans two columns, region ends at hcount 8
        vcount = 10'd0;
        for (int i = 0; i < 14; i++) begin
            if (i >= 1 && i <= 8) check("b_rom_addr", rom_addr_b, addr_b[i-1]);
            if (i >= 4) begin
                check("b_pixel", pixel_b, exp_b[i-4]);
                check("b_opaque", opaque_b, exp_b[i-4] != 24'h0);
            end
            if (i < 10) hcount = 11'(i);
            next_cycle();
        end

        // loop mode, 3 frames, step every 2 ticks
        for (int i = 0; i < 8; i++) begin
            check("c_loop_frame", cur_c, seq_loop[i]);
            tick_c = 1'b1; next_cycle();
            tick_c = 1'b0; next_cycle();
        end

        // ping-pong after a restart
        start_c = 1'b1; mode_c = 2'b11; next_cycle();
        start_c = 1'b0; next_cycle();
        for (int i = 0; i < 12; i++) begin
            check("c_pingpong_frame", cur_c, seq_pp[i]);
            tick_c = 1'b1; next_cycle();
            tick_c = 1'b0; next_cycle();
        end
        // leave the counter at 1, then start together with a tick
        tick_c = 1'b1; next_cycle();
        tick_c = 1'b0; next_cycle();
        start_c = 1'b1; tick_c = 1'b1; next_cycle();
        start_c = 1'b0; tick_c = 1'b0;
        check("c_start_frame", cur_c, 0);
        next_cycle();
        tick_c = 1'b1; next_cycle(); tick_c = 1'b0;
        check("c_start_tick1_frame", cur_c, 0);
        next_cycle();
        tick_c = 1'b1; next_cycle(); tick_c = 1'b0;
        check("c_start_tick2_frame", cur_c, 1);
        next_cycle();

        // hold mode clamps frame_sel
        mode_c = 2'b00; sel_c = 8'd7;
        tick_c = 1'b1; next_cycle(); tick_c = 1'b0;
        check("c_hold_clamp", cur_c, 2);
        sel_c = 8'd1;
        tick_c = 1'b1; next_cycle(); tick_c = 1'b0;
        check("c_hold_sel", cur_c, 1);
        next_cycle();

        // one-shot, 3 frames, step on every tick
        tick_d = 1'b1; next_cycle(); tick_d = 1'b0;
        check("d_tick1_frame", cur_d, 1);
        check("d_tick1_done", done_d, 0);
        next_cycle();
        tick_d = 1'b1; next_cycle(); tick_d = 1'b0;
        check("d_tick2_frame", cur_d, 2);
        check("d_tick2_done", done_d, 1);
        next_cycle();
        check("d_done_pulse_end", done_d, 0);
        tick_d = 1'b1; next_cycle(); tick_d = 1'b0;
        check("d_stopped_frame", cur_d, 2);
        check("d_stopped_done", done_d, 0);
        next_cycle();
        start_d = 1'b1; tick_d = 1'b1; next_cycle();
        start_d = 1'b0; tick_d = 1'b0;
        check("d_start_frame", cur_d, 0);
        check("d_start_done", done_d, 0);
        next_cycle();
        tick_d = 1'b1; next_cycle(); tick_d = 1'b0;
        check("d_rerun_frame", cur_d, 1);
        next_cycle();

        // mid-line reset while drawing frame 1 of instance A
        sel_a = 8'd1;
        tick_a = 1'b1; next_cycle(); tick_a = 1'b0;
        check("a_hold_frame", cur_a, 1);
        vcount = 10'd6; hcount = 11'd12;
        repeat (5) next_cycle();
        check("a_pre_reset_pixel", pixel_a, 24'h0e0e0e);
        reset = 1'b1; next_cycle(); reset = 1'b0;
        check("a_reset_frame", cur_a, 0);
        for (int i = 0; i < 4; i++) begin
            check("a_reset_pixel", pixel_a, 0);
            check("a_reset_opaque", opaque_a, 0);
            next_cycle();
        end
        check("a_resume_pixel", pixel_a, 24'h060606);
        check("a_resume_opaque", opaque_a, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/anim_sprite_renderer.md
Name: anim_sprite_renderer

Overview:
- Parametrised sprite renderer for the VGA pixel pipeline: draws a multi-frame, integer-scaled, palette-indexed sprite at (x,y).
- Image indices come from an external single-port ROM; colours come from an external 24-bit palette ROM. Both ROMs have 1-cycle synchronous read.
- Adds animation (hold / loop / one-shot / ping-pong), power-of-two scaling and a transparent colour key.
- Output latency is fixed and documented, so the mixer can align sprite layers exactly.

Parameters:
- WIDTH, 180, source frame width in texels
- HEIGHT, 180, source frame height in texels
- FRAMES, 4, number of frames stored back-to-back in image ROM (frame f at base f*WIDTH*HEIGHT); 1..256
- SCALE_LOG2, 0, on-screen size = WIDTH<<SCALE_LOG2 by HEIGHT<<SCALE_LOG2
- FRAME_PERIOD, 8, frame_tick pulses per animation step; >=1
- ROM_AW, 20, image ROM address width
- TRANSPARENT_IDX, 8'h00, palette index treated as transparent

Ports:
- pixel_clk  in  1  sole clock
- reset  in  1  synchronous, active-high
- x  in  11  sprite left edge, screen coords
- y  in  10  sprite top edge
- hcount  in  11  current pixel column
- vcount  in  10  current pixel row
- frame_tick  in  1  one-cycle pulse per video frame (start of vblank)
- mode  in  2  00 hold, 01 loop, 10 one-shot, 11 ping-pong
- frame_sel  in  8  frame shown in hold mode
- start  in  1  one-cycle pulse; restarts animation at frame 0
- rom_addr  out  ROM_AW  image ROM address (combinational)
- rom_data  in  8  palette index, valid 1 cycle after rom_addr
- cmap_addr  out  8  palette ROM address (registered)
- cmap_data  in  24  {R,G,B}, valid 1 cycle after cmap_addr
- pixel  out  24  sprite colour, 0 when not drawn
- opaque  out  1  1 when pixel is a drawn, non-transparent texel
- cur_frame  out  8  frame index currently displayed
- done  out  1  one-cycle pulse when one-shot reaches its last frame

Behaviour:
- Reset values: pixel=0, opaque=0, cur_frame=0, done=0, cmap_addr=0, tick counter=0, direction=up, FSM=RUN. All pipeline valid bits clear.
- Inside test:
  - Uses 12-bit zero-extended compares: x <= hcount < x+(WIDTH<<SCALE_LOG2), and likewise for y/vcount with HEIGHT.
  - No wrap: x near 2047 simply clips.
- Address: rom_addr = cur_frame*WIDTH*HEIGHT + ((vcount-y)>>SCALE_LOG2)*WIDTH + ((hcount-x)>>SCALE_LOG2), truncated to ROM_AW. When not inside, the value is don't-care.
- Pipeline, 4 edges total; the inside flag travels in a matching 4-stage shift register:
  - edge1: ROM captures rom_addr.
  - edge2: cmap_addr <= rom_data; index also registered.
  - edge3: palette read.
  - edge4: pixel/opaque registered.
- pixel/opaque after edge N correspond to hcount/vcount sampled at edge N-4 (after edge4 counting from the sample).
- Output rule: if inside_d and index != TRANSPARENT_IDX, then pixel=cmap_data and opaque=1. Otherwise pixel=0 and opaque=0.
- Animation: a tick counter counts frame_tick pulses 0..FRAME_PERIOD-1. A step occurs on the tick where the counter equals FRAME_PERIOD-1; the counter then returns to 0.
- cur_frame changes only on a frame_tick cycle, so no tearing mid-frame.
- Modes:
  - hold: cur_frame = min(frame_sel, FRAMES-1), updated on each frame_tick. The counter keeps running.
  - loop: on step, cur_frame = (cur_frame==FRAMES-1) ? 0 : cur_frame+1.
  - one-shot, FSM RUN: on step, increment. On the step reaching FRAMES-1, pulse done for 1 cycle and go to STOPPED. STOPPED holds the last frame until start.
  - ping-pong: step in the current direction; reverse at 0 and FRAMES-1 (sequence 0,1,..,F-1,F-2,..,0,1..). With FRAMES=1 it stays at 0.
- start: cur_frame=0, counter=0, direction=up, FSM=RUN, next cycle. start outranks a simultaneous frame_tick, and that tick is not counted.
- mode change: takes effect at the next step/tick. cur_frame is not reset, but it is clamped to FRAMES-1 if out of range.
- FRAMES=1: cur_frame is always 0; in one-shot, done pulses on the first step.
- Reset mid-line: pipeline valids clear, so pixel=0 for the next 4 cycles regardless of the ROMs.

Test Plan:
- WIDTH=4, HEIGHT=2, FRAMES=2, SCALE_LOG2=0; x=10, y=5; sweep hcount 8..16 on vcount=6; ROM = address, palette = {idx,idx,idx} -> after 4 edges, hcount 10..13 give pixel 0x040404..0x070707 and opaque=1; others pixel=0.
- Same setup with ROM value 0 at address 5 -> the texel at hcount=11, vcount=6 gives pixel=0, opaque=0 (transparent key).
- SCALE_LOG2=1, x=0, y=0 -> hcount 0,1 both read address 0 and hcount 2,3 read address 1; the region ends at hcount 8.
- FRAMES=3, FRAME_PERIOD=2, loop mode; 8 frame_ticks -> cur_frame sequence 0,0,1,1,2,2,0,0. In ping-pong mode, 12 ticks -> 0,0,1,1,2,2,1,1,0,0,1,1.
- One-shot, FRAMES=3, FRAME_PERIOD=1 -> cur_frame 1, then 2; done is high exactly one cycle, on the second tick; further ticks hold 2. start together with a tick -> cur_frame=0 and the counter is 0.
- Assert reset for 1 cycle while inside the sprite -> pixel=0 and opaque=0 for 4 cycles, cur_frame=0; normal output resumes on the 5th edge.
